// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator behind a valid/ready handshake.
// A 2-entry skid buffer keeps full throughput with IN_READY driven from registers only.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INST,
  input  logic [3:0]       SELECT,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  OUT,
  output logic [TAG_W-1:0] OUT_TAG
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1 || TAG_W > 64) begin : g_bad_tag
    $error("imm_gen_pipe: TAG_W must be in 1..64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  // Every signed format has its MSB at INST[31]; decode into 64 bits, then truncate.
  logic        sgn;
  logic [63:0] ext;
  always_comb begin
    sgn = INST[31] & ~SELECT[3];
    ext = '0;
    case (SELECT[2:0])
      3'b000:  ext = {{32{sgn}}, INST[31:12], 12'b0};
      3'b001:  ext = {{43{sgn}}, INST[31], INST[19:12], INST[20], INST[30:21], 1'b0};
      3'b010:  ext = {{52{sgn}}, INST[31:20]};
      3'b011:  ext = {{51{sgn}}, INST[31], INST[7], INST[30:25], INST[11:8], 1'b0};
      3'b100:  ext = {{52{sgn}}, INST[31:25], INST[11:7]};
      3'b101:  ext = (XLEN == 64) ? {58'b0, INST[25:20]} : {59'b0, INST[24:20]};
      3'b110:  ext = {59'b0, INST[19:15]};
      default: ext = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{INST[6:0], ext};

  entry_t din;
  assign din = '{imm: ext[XLEN-1:0], tag: IN_TAG};

  state_t state;
  entry_t head, skid;
  logic   acc, cons;

  assign acc  = IN_VALID & IN_READY;
  assign cons = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
    end else if (FLUSH) begin
      state     <= EMPTY;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          head      <= din;
          state     <= ONE;
          OUT_VALID <= 1'b1;
        end
        ONE: begin
          if (acc && cons) begin
            head <= din;
          end else if (acc) begin
            skid     <= din;
            state    <= TWO;
            IN_READY <= 1'b0;
          end else if (cons) begin
            state     <= EMPTY;
            OUT_VALID <= 1'b0;
          end
        end
        TWO: if (cons) begin
          head     <= skid;
          state    <= ONE;
          IN_READY <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          IN_READY  <= 1'b1;
          OUT_VALID <= 1'b0;
        end
      endcase
    end
  end

  assign OUT     = head.imm;
  assign OUT_TAG = head.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: XLEN=32 and XLEN=64 instances share one stimulus stream and one
// expectation queue; a negedge monitor checks handshake state, stability and data.
module tb_imm_gen_pipe;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, IN_VALID, OUT_READY;
  logic [31:0] INST;
  logic [3:0]  SELECT;
  logic [7:0]  IN_TAG;

  logic        rdy32, vld32, rdy64, vld64;
  logic [31:0] out32;
  logic [63:0] out64;
  logic [7:0]  tag32, tag64;

  always #5 CLK = ~CLK;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(rdy32),
    .INST(INST), .SELECT(SELECT), .IN_TAG(IN_TAG), .OUT_VALID(vld32),
    .OUT_READY(OUT_READY), .OUT(out32), .OUT_TAG(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(rdy64),
    .INST(INST), .SELECT(SELECT), .IN_TAG(IN_TAG), .OUT_VALID(vld64),
    .OUT_READY(OUT_READY), .OUT(out64), .OUT_TAG(tag64));

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Field value and width per format, then two's-complement arithmetic for sign extension.
  function automatic logic [63:0] model(logic [31:0] inst, logic [3:0] sel, int xlen);
    logic [63:0] f;
    longint      v;
    int          w;
    bit          signed_fmt;
    f = '0;
    w = 1;
    signed_fmt = !sel[3];
    case (sel[2:0])
      3'd0: begin f[31:0] = {inst[31:12], 12'h000}; w = 32; end
      3'd1: begin f[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; w = 21; end
      3'd2: begin f[11:0] = inst[31:20]; w = 12; end
      3'd3: begin f[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; w = 13; end
      3'd4: begin f[11:0] = {inst[31:25], inst[11:7]}; w = 12; end
      3'd5: begin
        if (xlen == 64) f[5:0] = inst[25:20]; else f[4:0] = inst[24:20];
        signed_fmt = 0;
      end
      3'd6: begin f[4:0] = inst[19:15]; signed_fmt = 0; end
      default: signed_fmt = 0;
    endcase
    if (signed_fmt && f[w-1]) v = longint'(f) - (longint'(1) << w);
    else v = longint'(f);
    if (xlen == 32) return {32'h0, v[31:0]};
    return v;
  endfunction

  // Monitor: queue depth is the reference occupancy for OUT_VALID/IN_READY.
  logic        prev_hold = 1'b0;
  logic [31:0] p32;
  logic [63:0] p64;
  logic [7:0]  pt;
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      q.delete();
      prev_hold = 1'b0;
    end else begin
      check("out_valid32", vld32, q.size() != 0);
      check("out_valid64", vld64, q.size() != 0);
      check("in_ready32", rdy32, q.size() < 2);
      check("in_ready64", rdy64, q.size() < 2);
      if (prev_hold) begin
        check("hold_out32", out32, p32);
        check("hold_out64", out64, p64);
        check("hold_tag", tag32, pt);
      end
      prev_hold = vld32 && !OUT_READY && !FLUSH;
      p32 = out32; p64 = out64; pt = tag32;
      if (vld32 && OUT_READY) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got tag %h expected no output", tag32);
        end else begin
          e = q.pop_front();
          check("imm32", out32, e.e32);
          check("imm64", out64, e.e64);
          check("tag32", tag32, e.tag);
          check("tag64", tag64, e.tag);
        end
      end
      if (FLUSH) q.delete();
    end
  end

  // One cycle of stimulus; the expectation is queued only if the next edge accepts it.
  task automatic drive(bit v, logic [31:0] inst, logic [3:0] sel, logic [7:0] tag,
                       bit ordy, bit fl, bit use_k, logic [31:0] k32, logic [63:0] k64,
                       output bit accepted);
    exp_t        e;
    logic [63:0] m;
    @(posedge CLK); #1;
    IN_VALID = v; INST = inst; SELECT = sel; IN_TAG = tag; OUT_READY = ordy; FLUSH = fl;
    @(negedge CLK); #1;
    accepted = v && rdy32 && !fl && !RESET;
    if (accepted) begin
      if (use_k) begin
        e.e32 = k32; e.e64 = k64;
      end else begin
        m = model(inst, sel, 32);
        e.e32 = m[31:0];
        e.e64 = model(inst, sel, 64);
      end
      e.tag = tag;
      q.push_back(e);
    end
  endtask

  task automatic idle(bit ordy);
    bit a;
    drive(0, 32'h0, 4'h0, 8'h0, ordy, 0, 0, 32'h0, 64'h0, a);
  endtask

  task automatic send(logic [31:0] inst, logic [3:0] sel, logic [7:0] tag, bit ordy,
                      bit use_k, logic [31:0] k32, logic [63:0] k64);
    bit a;
    a = 0;
    for (int i = 0; i < 8 && !a; i++) drive(1, inst, sel, tag, ordy, 0, use_k, k32, k64, a);
    if (!a) begin
      checks++; errors++;
      $display("FAIL accept_timeout: tag %h not accepted within 8 cycles", tag);
    end
  endtask

  initial begin
    bit a;
    RESET = 1; FLUSH = 0; IN_VALID = 0; OUT_READY = 0; INST = 0; SELECT = 0; IN_TAG = 0;
    #12;
    check("rst_valid", {vld32, vld64}, 2'b00);
    check("rst_ready", {rdy32, rdy64}, 2'b11);
    check("rst_out", {out32, out64}, 96'h0);
    check("rst_tag", {tag32, tag64}, 16'h0);
    @(posedge CLK); #2 RESET = 0;

    // Known encodings with hand-derived results
    send(32'hFFF00093, 4'b0010, 8'h10, 1, 1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    send(32'hFFF00093, 4'b1010, 8'h11, 1, 1, 32'h00000FFF, 64'h0000000000000FFF);
    send(32'hFE000EE3, 4'b0011, 8'h12, 1, 1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    send(32'h0080006F, 4'b0001, 8'h13, 1, 1, 32'h00000008, 64'h0000000000000008);
    send(32'h800000B7, 4'b0000, 8'h14, 1, 1, 32'h80000000, 64'hFFFFFFFF80000000);
    send(32'h03F09093, 4'b0101, 8'h15, 1, 1, 32'h0000001F, 64'h000000000000003F);
    send(32'h800000B7, 4'b1000, 8'h16, 1, 1, 32'h80000000, 64'h0000000080000000);
    send(32'hFFFFFFFF, 4'b0111, 8'h17, 1, 1, 32'h00000000, 64'h0);
    repeat (3) idle(1);

    // Backpressure: two accepts fill the buffer, the third must stall
    send(32'h00100093, 4'b0010, 8'd1, 0, 0, 0, 0);
    send(32'h00200093, 4'b0010, 8'd2, 0, 0, 0, 0);
    drive(1, 32'h00300093, 4'b0010, 8'd3, 0, 0, 0, 0, 0, a);
    check("bp_stall_accept", a, 1'b0);
    check("bp_in_ready", rdy32, 1'b0);
    check("bp_head_tag", tag32, 8'd1);
    send(32'h00300093, 4'b0010, 8'd3, 1, 0, 0, 0);
    send(32'h00400093, 4'b0010, 8'd4, 1, 0, 0, 0);
    repeat (4) idle(1);

    // Flush from full with a request presented in the same cycle
    send(32'h12345013, 4'b0010, 8'hA1, 0, 0, 0, 0);
    send(32'h12345013, 4'b0100, 8'hA2, 0, 0, 0, 0);
    drive(1, 32'hABCDE013, 4'b0010, 8'hEE, 0, 1, 0, 0, 0, a);
    idle(1);
    check("flush_valid", vld32, 1'b0);
    check("flush_ready", rdy32, 1'b1);
    repeat (3) idle(1);

    // Asynchronous reset between edges while full
    send(32'h0000A0B7, 4'b0000, 8'hB1, 0, 0, 0, 0);
    send(32'h0000B0B7, 4'b0000, 8'hB2, 0, 0, 0, 0);
    @(posedge CLK); #2 RESET = 1;
    #1;
    check("arst_valid", {vld32, vld64}, 2'b00);
    check("arst_ready", {rdy32, rdy64}, 2'b11);
    check("arst_out", {out32, out64}, 96'h0);
    check("arst_tag", {tag32, tag64}, 16'h0);
    @(posedge CLK); #2 RESET = 0; IN_VALID = 0;
    send(32'hFFF00093, 4'b0010, 8'hC1, 1, 1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    idle(1);
    check("lat_valid", vld32, 1'b1);
    check("lat_out", out32, 32'hFFFFFFFF);
    check("lat_tag", tag32, 8'hC1);
    idle(1);

    // Randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 70, $urandom, 4'($urandom), 8'($urandom),
            $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 3, 0, 0, 0, a);
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    check("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate-generation stage for the decode pipeline.
- Decodes all RV32/RV64 immediate formats (U, J, I, B, S, SHAMT, CSR zimm) with a per-request sign/zero mode.
- Wraps the decode in a valid/ready handshake with a 2-entry skid buffer, so the stage runs at full throughput under backpressure.
- Carries an opaque tag (PC/rd/ROB id) alongside each result; supports a pipeline flush.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 8, width of the opaque tag travelling with each request; legal range 1..64.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous flush; discards all buffered entries.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  stage can accept a request.
- INST  in  32  instruction word.
- SELECT  in  4  [2:0] format, [3] unsigned (zero-extend) mode.
- IN_TAG  in  TAG_W  tag for the request.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- OUT  out  XLEN  decoded immediate.
- OUT_TAG  out  TAG_W  tag of the result.

Behaviour:
- Handshakes:
  - Input accepted when IN_VALID & IN_READY at a rising edge.
  - Output consumed when OUT_VALID & OUT_READY at a rising edge.
- Format decode (raw field, then extension), SELECT[2:0]:
  - 000 U: {INST[31:12], 12'b0}.
  - 001 J: {INST[31], INST[19:12], INST[20], INST[30:21], 1'b0}, 21 bits.
  - 010 I: INST[31:20].
  - 011 B: {INST[31], INST[7], INST[30:25], INST[11:8], 1'b0}, 13 bits.
  - 100 S: {INST[31:25], INST[11:7]}.
  - 101 SHAMT: INST[24:20] when XLEN=32; INST[25:20] when XLEN=64. Always zero-extended.
  - 110 ZIMM: INST[19:15]. Always zero-extended.
  - 111: zero.
- Extension:
  - Formats 000..100 sign-extend from their MSB to XLEN when SELECT[3]=0, zero-extend when SELECT[3]=1.
  - U with XLEN=64 sign-extends from bit 31.
- Decode is combinational on the input side. The result is registered with its tag at acceptance, so entries store the final immediate, not INST.
- Occupancy state machine:
  - States EMPTY(0), ONE(1), TWO(2). The head entry drives OUT/OUT_TAG.
  - EMPTY: accept -> ONE.
  - ONE: accept & consume -> ONE (new entry becomes head). Accept only -> TWO. Consume only -> EMPTY. Neither -> ONE.
  - TWO: consume -> ONE (skid entry promoted to head). No accept is possible in TWO.
- Outputs from state:
  - IN_READY = (state != TWO). Derived from registers only; no combinational path from OUT_READY.
  - OUT_VALID = (state != EMPTY).
- Latency and ordering:
  - Request accepted at edge n appears on OUT at edge n+1 at the earliest.
  - Sustained throughput is 1 per cycle when OUT_READY stays high.
  - Results are delivered strictly in acceptance order.
- OUT/OUT_TAG hold their value while OUT_VALID & !OUT_READY (stable under backpressure). When OUT_VALID=0, OUT retains its last value; consumers must not sample it.
- FLUSH:
  - Next state is EMPTY, with OUT_VALID=0 and IN_READY=1.
  - A request presented in the same cycle is dropped.
  - An output handshake in the same cycle still counts as delivered to the consumer.
  - FLUSH has priority over all other transitions.
- RESET (asynchronous, any time, including mid-transfer):
  - State EMPTY; OUT_VALID=0; IN_READY=1; OUT=0; OUT_TAG=0; skid entry cleared.
  - After deassertion, the first edge behaves as in EMPTY.
- Elaboration check: XLEN outside {32,64} is an elaboration error.

Test Plan:
- Sign/zero I-type, XLEN=32:
  - INST=0xFFF00093 (addi x1,x0,-1), SELECT=0010 -> OUT=0xFFFFFFFF one cycle after acceptance.
  - Same INST, SELECT=1010 -> OUT=0x00000FFF.
- Branch and jump, XLEN=32:
  - INST=0xFE000EE3 (beq x0,x0,-4), SELECT=0011 -> 0xFFFFFFFC.
  - INST=0x0080006F (jal x0,8), SELECT=0001 -> 0x00000008.
- XLEN=64:
  - INST=0x800000B7 (lui x1,0x80000), SELECT=0000 -> 0xFFFFFFFF80000000.
  - INST=0x03F09093 (slli, shamt 63), SELECT=0101 -> 0x000000000000003F.
- Backpressure: stream tags 1,2,3,4 back-to-back with OUT_READY=0 for 3 cycles, then 1.
  - IN_READY drops after 2 accepts; OUT holds tag 1 stable.
  - Then tags are delivered 1,2,3,4 in order with no loss or duplication.
- Flush: state TWO, assert FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, and the flushed-cycle request never appears at the output.
- Reset mid-operation: assert RESET asynchronously between edges while in TWO.
  - Immediately OUT_VALID=0, IN_READY=1, OUT=0, OUT_TAG=0.
  - After release, a single request emerges after exactly 1 cycle.
